maxnet_ctrl: RTL
================

# maxnet_ctrl

Iteration controller that sits directly upstream of the PLU in the MAXNET datapath. It loads four IEEE-754 single-precision activations and drives the PLU one neuron at a time with the activation vector and that neuron's weight row. It applies ReLU to each PLU result and writes the four results back as the next activation vector. It repeats until at most one activation is nonzero, or until an iteration cap is hit, and then reports the winning neuron.

## Interface
- EPS, default 32'h3E000000 (0.125): lateral-inhibition magnitude as float32; must be below 0.25 for N=4.
- MAX_ITER, default 32: iteration cap, in the range 1..255.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-low.
- start  in  1  one-cycle request; ignored while busy=1.
- x1..x4  in  32 each  initial activations; sampled in the cycle after start is accepted.
- plu_done  in  1  one-cycle pulse from the PLU; plu_out is valid in the same cycle.
- plu_out  in  32  PLU dot-product result.
- plu_start  out  1  one-cycle pulse to the PLU.
- a1..a4  out  32 each  current activation vector; PLU activation inputs.
- w1..w4  out  32 each  weight row for the current neuron; PLU weight inputs.
- busy  out  1  high from acceptance of start until done.
- done  out  1  one-cycle completion pulse.
- winner  out  2  index (0..3) of the surviving neuron.
- winner_valid  out  1  high when exactly one activation is nonzero.
- timeout  out  1  high when the iteration cap was reached without convergence.
- iter_count  out  8  number of completed iterations.

## Operation
- States:
  - IDLE: on start, go to LOAD.
  - LOAD: latch x1..x4 into act[0..3]; clear iter_count, winner, winner_valid and timeout; set k=0; go to ISSUE.
  - ISSUE: assert plu_start for one cycle; go to WAIT.
  - WAIT: hold until plu_done. In the plu_done cycle, nxt[k] = ReLU(plu_out). If k<3, increment k and go to ISSUE; otherwise go to CHECK.
  - CHECK: act ← nxt; iter_count++; count the nonzero entries of nxt.
    - If count ≤ 1, go to FIN.
    - Else if the new iter_count == MAX_ITER, set timeout=1 and go to FIN.
    - Else set k=0 and go to ISSUE.
  - FIN: done=1 for one cycle; go to IDLE.
- Weight row k: w(j) = 32'h3F800000 (1.0) when j==k, otherwise {1'b1, EPS[30:0]} (−EPS). The row is decoded combinationally from k.
- ReLU: if bit 31 is set, the result is 32'h00000000; otherwise the value passes unchanged. −0 (32'h80000000) therefore becomes +0.
- A value is nonzero when bits [30:0] != 0.
- Convergence is checked only after an iteration completes. At least one iteration always runs.
- Result outputs in FIN:
  - count==1: winner = index of the nonzero entry, winner_valid=1.
  - count==0: winner=0, winner_valid=0.
- winner, winner_valid, timeout, iter_count and a1..a4 hold their values until the next start is accepted.
- There is no internal watchdog on plu_done.

## Timing
- Reset (rst=0 at a clock edge) puts every output at 0:
  - a1..a4, w1..w4, plu_start, busy, done, winner, winner_valid, timeout, iter_count.
  - The state returns to IDLE.
- Reset mid-operation aborts immediately. A plu_done arriving after reset is ignored.
- busy rises in the LOAD cycle and falls in the cycle after FIN.
- a1..a4 and w1..w4 are stable from the ISSUE cycle through the plu_done cycle.
- With a PLU latency of L cycles (plu_start to plu_done), each neuron takes 1+L cycles. One iteration takes 4(1+L)+1 cycles.
- Total latency from start to done is 1 + iterations·(4(1+L)+1) + 1 cycles.
- plu_done outside WAIT is ignored. start in the same cycle as done is ignored.

## Test plan
- Ideal-float PLU model, L=3, x={5.2, 6.8, 1.0, 4.3}, EPS=0.125 → after iteration 1 act = {3.6875, 5.4875, 0, 2.675} (within 1 ulp of the model); final result done, winner=1, winner_valid=1, timeout=0.
- x={0, 0, 3.0, 0} → done after 1 iteration; iter_count=1, winner=2, winner_valid=1, a3=32'h40400000.
- x all 32'h00000000, including a case where the PLU returns 32'h80000000 → iter_count=1, winner_valid=0, a1..a4 all 0.
- x={2.0, 2.0, 2.0, 2.0}, MAX_ITER=32 → timeout=1, iter_count=32, winner_valid=0; every state-to-state transition count matches the formula above.
- Protocol checks: exactly 4 plu_start pulses per iteration, each with w(k)=1.0 on the diagonal and 32'hBE000000 elsewhere; a start pulsed mid-run has no effect.
- Reset asserted during WAIT of iteration 2 → all outputs 0 on the next edge; a stray plu_done is ignored; a fresh start then completes normally.

Source files
------------

// File: rtl/maxnet_ctrl_if.sv
// rtl/maxnet_ctrl_if.sv - host and PLU-facing signal bundle for the MAXNET iteration controller
interface maxnet_ctrl_if;
    logic        start;
    logic [31:0] x1, x2, x3, x4;
    logic        plu_done;
    logic [31:0] plu_out;
    logic        plu_start;
    logic [31:0] a1, a2, a3, a4;
    logic [31:0] w1, w2, w3, w4;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        winner_valid;
    logic        timeout;
    logic [7:0]  iter_count;

    modport slave (
        input  start, x1, x2, x3, x4, plu_done, plu_out,
        output plu_start, a1, a2, a3, a4, w1, w2, w3, w4,
               busy, done, winner, winner_valid, timeout, iter_count
    );

    modport master (
        output start, x1, x2, x3, x4, plu_done, plu_out,
        input  plu_start, a1, a2, a3, a4, w1, w2, w3, w4,
               busy, done, winner, winner_valid, timeout, iter_count
    );
endinterface

// File: rtl/maxnet_ctrl.sv
// rtl/maxnet_ctrl.sv - MAXNET winner-take-all iteration controller driving the PLU
module maxnet_ctrl #(
    parameter logic [31:0] EPS      = 32'h3E000000,
    parameter int          MAX_ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    maxnet_ctrl_if.slave  bus
);
    localparam logic [31:0] ONE     = 32'h3F800000;
    localparam logic [31:0] NEG_EPS = {1'b1, EPS[30:0]};

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, FIN} state_t;

    state_t          state;
    logic [1:0]      k;
    logic [3:0][31:0] act;
    logic [3:0][31:0] nxt;
    logic [3:0][31:0] w_row;
    logic            plu_start_q, busy_q, done_q, winner_valid_q, timeout_q;
    logic [1:0]      winner_q;
    logic [7:0]      iter_q;
    logic [7:0]      iter_next;
    logic [3:0]      nz;
    logic [2:0]      nz_cnt;
    logic [1:0]      win_idx;
    logic [31:0]     relu_out;

    assign relu_out  = bus.plu_out[31] ? 32'h0 : bus.plu_out;
    assign iter_next = iter_q + 8'd1;

    // Weight row is a pure decode of k; gated by busy so it reads zero when idle.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_row[j] = '0;
            if (busy_q)
                w_row[j] = (k == 2'(j)) ? ONE : NEG_EPS;
        end
    end

    // Survivor count over the freshly computed vector; win_idx is meaningful only when count is 1.
    always_comb begin
        nz_cnt  = '0;
        win_idx = '0;
        nz      = '0;
        for (int j = 0; j < 4; j++) begin
            nz[j]  = |nxt[j][30:0];
            nz_cnt = nz_cnt + {2'b00, nz[j]};
            if (nz[j])
                win_idx = 2'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            k              <= '0;
            act            <= '0;
            nxt            <= '0;
            plu_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            iter_q         <= '0;
        end else begin
            plu_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    act            <= {bus.x4, bus.x3, bus.x2, bus.x1};
                    iter_q         <= '0;
                    winner_q       <= '0;
                    winner_valid_q <= 1'b0;
                    timeout_q      <= 1'b0;
                    k              <= '0;
                    plu_start_q    <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.plu_done) begin
                        nxt[k] <= relu_out;
                        if (k != 2'd3) begin
                            k           <= k + 2'd1;
                            plu_start_q <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    act    <= nxt;
                    iter_q <= iter_next;
                    if (nz_cnt <= 3'd1) begin
                        winner_q       <= (nz_cnt == 3'd1) ? win_idx : 2'd0;
                        winner_valid_q <= (nz_cnt == 3'd1);
                        done_q         <= 1'b1;
                        state          <= FIN;
                    end else if (iter_next == 8'(MAX_ITER)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state     <= FIN;
                    end else begin
                        k           <= '0;
                        plu_start_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.plu_start    = plu_start_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.winner       = winner_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.iter_count   = iter_q;
    assign bus.a1           = act[0];
    assign bus.a2           = act[1];
    assign bus.a3           = act[2];
    assign bus.a4           = act[3];
    assign bus.w1           = w_row[0];
    assign bus.w2           = w_row[1];
    assign bus.w3           = w_row[2];
    assign bus.w4           = w_row[3];
endmodule
